// File: rtl/chess_clock_multi.sv
// chess_clock_multi
//   N-player chess clock. Each player owns an MM:SS BCD countdown that is
//   loaded from a 3-bit preset code. Only the player held in the active
//   register counts down, one second per TICK_DIV clocks, while the FSM is in
//   RUN. A player reaching 00:00 holds there, raises its flag bit and moves
//   the FSM to FLAGGED. Only a load leaves FLAGGED.
//
//   Optional build macro: CHESS_CLOCK_INCREMENT_EN
//     When defined, a switch of the active player while running adds INC_SEC
//     seconds (Fischer increment) to the outgoing player. The result
//     saturates at 99:59.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   load       preset load strobe; all players load, flags clear, FSM -> IDLE
//   preset     3 bits per player; player p uses preset[3p+2:3p]
//   start      start/resume strobe
//   pause      pause strobe
//   active     requested active player; values >= NUM_PLAYERS are ignored
//   m/c/d/u    registered BCD digits of the active player (MM:SS)
//   flag       per-player flag-fall bits
//   running    high while the FSM is in RUN
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 PAUSED, 3 FLAGGED)
//
// Handshake: there is no valid/ready flow. Every strobe is sampled on each
//   rising clk edge. When several arrive together, load beats pause, and
//   pause beats start.
module chess_clock_multi #(
  parameter int NUM_PLAYERS = 2,
  parameter int PID_W       = 3,
  parameter int TICK_DIV    = 50000000,
  parameter int INC_SEC     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [3*NUM_PLAYERS-1:0] preset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [PID_W-1:0]         active,
  output logic [3:0]               m,
  output logic [3:0]               c,
  output logic [3:0]               d,
  output logic [3:0]               u,
  output logic [NUM_PLAYERS-1:0]   flag,
  output logic                     running,
  output logic [1:0]               state_dbg
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || (1 << PID_W) < NUM_PLAYERS ||
      TICK_DIV < 2 || INC_SEC < 0 || INC_SEC > 59) begin : g_param_err
    $error("chess_clock_multi: illegal parameter combination");
  end

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_FLAGGED = 2'd3
  } state_t;

  // Preset code -> {m, c, d, u}. The seconds are always 00.
  function automatic logic [15:0] preset_time(input logic [2:0] code);
    logic [7:0] mins;
    case (code)
      3'b000:  mins = 8'h05;
      3'b001:  mins = 8'h10;
      3'b010:  mins = 8'h15;
      3'b011:  mins = 8'h20;
      3'b100:  mins = 8'h30;
      default: mins = 8'h70;
    endcase
    return {mins, 8'h00};
  endfunction

  // One-second BCD decrement. The caller guarantees that t is not 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] tm, tc, td, tu;
    {tm, tc, td, tu} = t;
    if (tu != 4'd0) tu = tu - 4'd1;
    else begin
      tu = 4'd9;
      if (td != 4'd0) td = td - 4'd1;
      else begin
        td = 4'd5;
        if (tc != 4'd0) tc = tc - 4'd1;
        else begin
          tc = 4'd9;
          tm = tm - 4'd1;
        end
      end
    end
    return {tm, tc, td, tu};
  endfunction

`ifdef CHESS_CLOCK_INCREMENT_EN
  localparam logic [6:0] INC_ADD = 7'(INC_SEC);
  // The switch tick and the increment fold into a single add.
  localparam logic [6:0] INC_NET = (INC_SEC > 0) ? 7'(INC_SEC - 1) : 7'd0;

  // Add seconds to an MM:SS value, saturating at 99:59.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] t,
                                              input logic [6:0]  add_s);
    logic [13:0] secs, mins, s;
    secs = 14'(t[15:12]) * 14'd600 + 14'(t[11:8]) * 14'd60 +
           14'(t[7:4]) * 14'd10 + 14'(t[3:0]) + 14'(add_s);
    if (secs > 14'd5999) secs = 14'd5999;
    mins = secs / 14'd60;
    s    = secs % 14'd60;
    return {4'(mins / 14'd10), 4'(mins % 14'd10), 4'(s / 14'd10), 4'(s % 14'd10)};
  endfunction

  logic inc_en;
  logic cur_flag;
`endif

  state_t                 state_q, state_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [PID_W-1:0]       active_q, active_d;
  logic [15:0]            time_q [NUM_PLAYERS];
  logic [15:0]            time_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] flag_q, flag_d;
  logic [15:0]            disp_q, disp_d;
  logic                   running_q, running_d;

  logic        act_chg, tick, hit_zero;
  logic [15:0] cur, dec_val, new_val;

  // Datapath: active sampling, prescaler, per-player digits and flags.
  always_comb begin
    active_d = (int'(active) < NUM_PLAYERS) ? active : active_q;
    act_chg  = (active_d != active_q);
    cur      = '0;
`ifdef CHESS_CLOCK_INCREMENT_EN
    cur_flag = 1'b0;
`endif
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (active_q == PID_W'(p)) begin
        cur = time_q[p];
`ifdef CHESS_CLOCK_INCREMENT_EN
        cur_flag = flag_q[p];
`endif
      end
    end
    tick = (state_q == S_RUN) && (presc_q == TICK_LAST);
    // A player already at 00:00 stays there and flags on its first tick.
    dec_val  = (cur == 16'h0000) ? cur : bcd_dec(cur);
    hit_zero = tick && (dec_val == 16'h0000);
    new_val  = tick ? dec_val : cur;
`ifdef CHESS_CLOCK_INCREMENT_EN
    inc_en = (state_q == S_RUN) && act_chg && !cur_flag;
    if (inc_en) begin
      if (!tick) new_val = bcd_add_sat(cur, INC_ADD);
      else if (INC_SEC > 0) begin
        new_val  = bcd_add_sat(cur, INC_NET);
        hit_zero = 1'b0;
      end
    end
`endif
    if (load || act_chg)     presc_d = '0;
    else if (state_q == S_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    else                     presc_d = presc_q;
    // The decrement on a switch edge still goes to the outgoing player.
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (load) begin
        time_d[p] = preset_time(preset[3*p +: 3]);
        flag_d[p] = 1'b0;
      end else begin
        time_d[p] = time_q[p];
        flag_d[p] = flag_q[p];
        if (active_q == PID_W'(p)) begin
          time_d[p] = new_val;
          if (hit_zero) flag_d[p] = 1'b1;
        end
      end
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (load) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE, S_PAUSED: if (start && !pause) state_d = S_RUN;
        S_RUN: begin
          if (hit_zero)   state_d = S_FLAGGED;
          else if (pause) state_d = S_PAUSED;
        end
        S_FLAGGED: state_d = S_FLAGGED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM / display outputs
  always_comb begin
    disp_d    = cur;
    running_d = (state_d == S_RUN);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      active_q  <= '0;
      flag_q    <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) time_q[p] <= '0;
    end else begin
      presc_q   <= presc_d;
      active_q  <= active_d;
      flag_q    <= flag_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      for (int p = 0; p < NUM_PLAYERS; p++) time_q[p] <= time_d[p];
    end
  end

  assign {m, c, d, u} = disp_q;
  assign flag         = flag_q;
  assign running      = running_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_chess_clock_multi.sv
module tb_chess_clock_multi;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [5:0]    preset = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [2:0]    active = '0;
  logic [3:0]    m, c, d, u;
  logic [NP-1:0] flag;
  logic          running;
  logic [1:0]    state_dbg;

  chess_clock_multi #(
    .NUM_PLAYERS(NP),
    .PID_W(3),
    .TICK_DIV(4),
    .INC_SEC(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .preset(preset),
    .start(start),
    .pause(pause),
    .active(active),
    .m(m),
    .c(c),
    .d(d),
    .u(u),
    .flag(flag),
    .running(running),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [5:0] pre;
    logic       st;
    logic       ps;
    logic [2:0] act;
    int         ncyc;
    logic [3:0] em, ec, ed, eu;
    logic [1:0] ef;
    logic       er;
    logic [1:0] es;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic ld, input logic [5:0] pre,
                              input logic st, input logic ps,
                              input logic [2:0] act, input int ncyc,
                              input logic [3:0] em, input logic [3:0] ec,
                              input logic [3:0] ed, input logic [3:0] eu,
                              input logic [1:0] ef, input logic er,
                              input logic [1:0] es);
    vec_t v;
    v.ld = ld; v.pre = pre; v.st = st; v.ps = ps; v.act = act; v.ncyc = ncyc;
    v.em = em; v.ec = ec; v.ed = ed; v.eu = eu; v.ef = ef; v.er = er; v.es = es;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [20:0] want_in);
    logic [20:0] got, want;
    exp_q.push_back(want_in);
    want = exp_q.pop_front();
    got  = {m, c, d, u, flag, running, state_dbg};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h%h:%h%h flag=%b run=%b st=%0d, required %h%h:%h%h flag=%b run=%b st=%0d",
               name, got[20:17], got[16:13], got[12:9], got[8:5], got[4:3], got[2], got[1:0],
               want[20:17], want[16:13], want[12:9], want[8:5], want[4:3], want[2], want[1:0]);
    end
  endtask

  // driver: strobes last one cycle, active is held; compare on a falling edge
  task automatic apply_vec(input string name, input vec_t v);
    load   = v.ld;
    preset = v.pre;
    start  = v.st;
    pause  = v.ps;
    active = v.act;
    for (int i = 0; i < v.ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
    end
    check(name, {v.em, v.ec, v.ed, v.eu, v.ef, v.er, v.es});
  endtask

  initial begin
    // Player 0 values once the 0->1 switch has happened in RUN
    logic [3:0] p0_c, p0_d, p0_u, p0_u2;
`ifdef CHESS_CLOCK_INCREMENT_EN
    p0_c = 4'd5; p0_d = 4'd0; p0_u = 4'd2; p0_u2 = 4'd1;
`else
    p0_c = 4'd4; p0_d = 4'd5; p0_u = 4'd7; p0_u2 = 4'd6;
`endif

    //          ld pre       st ps act ncyc  m  c  d  u  flag   run st
    // players at 00:00 after reset: flag on first tick
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 1,    0, 0, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 3,    0, 0, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 1,    0, 0, 0, 0, 2'b01, 0, 3));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 2,    0, 0, 0, 0, 2'b01, 0, 3));
    // load 05:00 / 10:00, count down
    vecs.push_back(mk(1, 6'b001000, 0, 0, 0, 2,    0, 5, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 1,    0, 5, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 9,    0, 4, 5, 8, 2'b00, 1, 1));
    // pause; pause+start together stays paused; prescaler holds its count
    vecs.push_back(mk(0, 6'b000000, 0, 1, 0, 1,    0, 4, 5, 8, 2'b00, 0, 2));
    vecs.push_back(mk(0, 6'b000000, 1, 1, 0, 5,    0, 4, 5, 8, 2'b00, 0, 2));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 1,    0, 4, 5, 8, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 3,    0, 4, 5, 7, 2'b00, 1, 1));
    // switch to player 1, who still shows 10:00 and then counts
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 2,    1, 0, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 4,    0, 9, 5, 9, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 2,    0, p0_c, p0_d, p0_u, 2'b00, 1, 1));
    // out-of-range active ignored; player 0 keeps counting
    vecs.push_back(mk(0, 6'b000000, 0, 0, 5, 4,    0, p0_c, p0_d, p0_u2, 2'b00, 1, 1));
    // count 05:00 down to 00:01, then flag at 00:00
    vecs.push_back(mk(1, 6'b000000, 0, 0, 0, 2,    0, 5, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 1,    0, 5, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 1197, 0, 0, 0, 1, 2'b00, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 3,    0, 0, 0, 1, 2'b01, 0, 3));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 1,    0, 0, 0, 0, 2'b01, 0, 3));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 0, 8,    0, 0, 0, 0, 2'b01, 0, 3));
    vecs.push_back(mk(0, 6'b000000, 1, 1, 0, 2,    0, 0, 0, 0, 2'b01, 0, 3));
    // remaining preset codes
    vecs.push_back(mk(1, 6'b001100, 0, 0, 0, 2,    3, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 2,    1, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 6'b111011, 0, 0, 1, 2,    7, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 0, 2,    2, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 6'b010101, 0, 0, 0, 2,    7, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 1, 2,    1, 5, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 6'b000000, 0, 0, 6, 2,    1, 5, 0, 0, 2'b00, 0, 0));

    // reset state
    repeat (3) @(negedge clk);
    check("reset_state", 21'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // asynchronous reset in the middle of RUN (player 1 at 15:00)
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("run_before_reset", {4'd1, 4'd4, 4'd5, 4'd9, 2'b00, 1'b1, 2'd1});
    #2 reset = 1'b0;
    #1 check("async_reset", 21'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_reset_release", 21'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
